// File: rtl/satp_pkg.sv
// Shared types and field helpers for the satp update sequencer.
// Field helpers work on a wide raw vector so any field widths can share them.
package satp_pkg;

  localparam int unsigned SATP_MAX = 128;

  typedef logic [SATP_MAX-1:0] satp_raw_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    ASID,
    GLOBAL
  } flush_kind_e;

  function automatic satp_raw_t satp_field(
    input satp_raw_t   v,
    input int unsigned lsb,
    input int unsigned w
  );
    satp_raw_t m;
    m = (satp_raw_t'(1) << w) - satp_raw_t'(1);
    return (v >> lsb) & m;
  endfunction

  function automatic satp_raw_t satp_mode(
    input satp_raw_t   v,
    input int unsigned mode_w,
    input int unsigned asid_w,
    input int unsigned ppn_w
  );
    return satp_field(v, asid_w + ppn_w, mode_w);
  endfunction

  function automatic satp_raw_t satp_asid(
    input satp_raw_t   v,
    input int unsigned asid_w,
    input int unsigned ppn_w
  );
    return satp_field(v, ppn_w, asid_w);
  endfunction

  function automatic satp_raw_t satp_ppn(
    input satp_raw_t   v,
    input int unsigned ppn_w
  );
    return satp_field(v, 0, ppn_w);
  endfunction

endpackage

// File: rtl/satp_update_sequencer_classify.sv
// Decides which TLB flush a satp change needs.
// A MODE or root PPN change invalidates every entry; an ASID change only the new ASID.
module satp_flush_classify
  import satp_pkg::*;
#(
  parameter int unsigned MODE_W = 4,
  parameter int unsigned ASID_W = 6,
  parameter int unsigned PPN_W  = 22,
  localparam int unsigned SATP_W = MODE_W + ASID_W + PPN_W
) (
  input  logic [SATP_W-1:0] old_val,
  input  logic [SATP_W-1:0] new_val,
  output flush_kind_e       kind
);

  satp_raw_t o;
  satp_raw_t n;
  logic      global_diff;
  logic      asid_diff;

  assign o = satp_raw_t'(old_val);
  assign n = satp_raw_t'(new_val);

  assign global_diff =
    (satp_mode(o, MODE_W, ASID_W, PPN_W) !=
     satp_mode(n, MODE_W, ASID_W, PPN_W)) ||
    (satp_ppn(o, PPN_W) != satp_ppn(n, PPN_W));

  assign asid_diff =
    satp_asid(o, ASID_W, PPN_W) !=
    satp_asid(n, ASID_W, PPN_W);

  // Global change dominates an ASID-only change
  always_comb begin
    kind = NONE;
    unique case (1'b1)
      global_diff:              kind = GLOBAL;
      !global_diff && asid_diff: kind = ASID;
      default:                  kind = NONE;
    endcase
  end

endmodule

// File: rtl/satp_update_sequencer.sv
// Owns satp: legalises software writes and sequences the TLB flush
// that must complete (or time out) before a new value is committed.
module satp_update_sequencer
  import satp_pkg::*;
#(
  parameter int unsigned MODE_W        = 4,
  parameter int unsigned ASID_W        = 6,
  parameter int unsigned PPN_W         = 22,
  parameter logic [(2**MODE_W)-1:0] ALLOWED_MODES = 16'h0002,
  parameter int unsigned ENFORCED_MODE = 1,
  parameter bit          STRICT        = 1'b0,
  parameter int unsigned FLUSH_TIMEOUT = 64,
  localparam int unsigned SATP_W = MODE_W + ASID_W + PPN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SATP_W-1:0] wr_data,
  output logic [SATP_W-1:0] satp_q,
  output logic              wr_reject,
  output logic              flush_req,
  output logic              flush_asid_only,
  output logic [ASID_W-1:0] flush_asid,
  input  logic              flush_ack,
  output logic              flush_timeout,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [SATP_W-1:0] SATP_RST =
    {MODE_W'(ENFORCED_MODE), {(ASID_W + PPN_W){1'b0}}};

  if (ALLOWED_MODES[0]) begin : g_bad_bare
    $error("ALLOWED_MODES bit 0 (bare) must be clear");
  end
  if (!ALLOWED_MODES[ENFORCED_MODE]) begin : g_bad_enf
    $error("ENFORCED_MODE must be a legal mode");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_tmo
    $error("FLUSH_TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  flush_kind_e       kind_q, kind_d;
  flush_kind_e       kind;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SATP_W-1:0] satp_d;
  logic [SATP_W-1:0] pend_q, pend_d;
  logic              reject_d;
  logic              tmo_d;

  logic [MODE_W-1:0] mode_in;
  logic              legal;
  logic              accept;
  logic              drop;
  logic [SATP_W-1:0] effective;

  assign mode_in = MODE_W'(satp_mode(satp_raw_t'(wr_data),
                                     MODE_W, ASID_W, PPN_W));
  assign legal   = ALLOWED_MODES[mode_in];
  assign accept  = wr_valid && (state_q == IDLE);
  assign drop    = !legal && STRICT;

  assign effective = legal ? wr_data :
    {MODE_W'(ENFORCED_MODE), wr_data[ASID_W+PPN_W-1:0]};

  satp_flush_classify #(
    .MODE_W (MODE_W),
    .ASID_W (ASID_W),
    .PPN_W  (PPN_W)
  ) u_classify (
    .old_val (satp_q),
    .new_val (effective),
    .kind    (kind)
  );

  // State, counter, committed and pending satp, output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kind_q        <= NONE;
      cnt_q         <= '0;
      satp_q        <= SATP_RST;
      pend_q        <= '0;
      wr_reject     <= 1'b0;
      flush_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cnt_q         <= cnt_d;
      satp_q        <= satp_d;
      pend_q        <= pend_d;
      wr_reject     <= reject_d;
      flush_timeout <= tmo_d;
    end
  end

  // Accept/classify in IDLE; wait for ack or timeout in FLUSH
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    satp_d   = satp_q;
    pend_d   = pend_q;
    reject_d = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          reject_d = !legal;
          if (!drop) begin
            if (kind == NONE) begin
              satp_d = effective;
            end else begin
              pend_d  = effective;
              kind_d  = kind;
              cnt_d   = '0;
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          satp_d  = pend_q;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          satp_d  = pend_q;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ready        = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign flush_req       = busy;
  assign flush_asid_only = busy && (kind_q == ASID);
  assign flush_asid      = busy ?
    ASID_W'(satp_asid(satp_raw_t'(pend_q), ASID_W, PPN_W)) : '0;

endmodule

// File: tb/tb_satp_update_sequencer.sv
// Directed bench for satp_update_sequencer, lenient and strict variants.
// Expected commits go through a scoreboard queue.
module tb_satp_update_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        wv0 = 1'b0, ack0 = 1'b0;
  logic [31:0] wd0 = '0;
  logic        rdy0, rej0, req0, fao0, tmo0, busy0;
  logic [31:0] q0;
  logic [5:0]  fa0;

  logic        wv1 = 1'b0, ack1 = 1'b0;
  logic [31:0] wd1 = '0;
  logic        rdy1, rej1, req1, fao1, tmo1, busy1;
  logic [31:0] q1;
  logic [5:0]  fa1;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  localparam logic [31:0] RST = {4'd1, 6'd0, 22'd0};

  always #5 clk = ~clk;

  satp_update_sequencer #(
    .STRICT (1'b0), .FLUSH_TIMEOUT (4)
  ) dut0 (
    .clk (clk), .rst_n (rst_n),
    .wr_valid (wv0), .wr_ready (rdy0), .wr_data (wd0),
    .satp_q (q0), .wr_reject (rej0), .flush_req (req0),
    .flush_asid_only (fao0), .flush_asid (fa0),
    .flush_ack (ack0), .flush_timeout (tmo0), .busy (busy0)
  );

  satp_update_sequencer #(
    .STRICT (1'b1), .FLUSH_TIMEOUT (4)
  ) dut1 (
    .clk (clk), .rst_n (rst_n),
    .wr_valid (wv1), .wr_ready (rdy1), .wr_data (wd1),
    .satp_q (q1), .wr_reject (rej1), .flush_req (req1),
    .flush_asid_only (fao1), .flush_asid (fa1),
    .flush_ack (ack1), .flush_timeout (tmo1), .busy (busy1)
  );

  function automatic logic [31:0] mk(
    input logic [3:0] m, input logic [5:0] a, input logic [21:0] p
  );
    return {m, a, p};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr0(input logic [31:0] d);
    wv0 = 1'b1;
    wd0 = d;
    step(1);
    wv0 = 1'b0;
    wd0 = 32'hdead_beef;
  endtask

  task automatic ack0_pulse();
    ack0 = 1'b1;
    step(1);
    ack0 = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] e;

    rst_n = 1'b0;
    step(2);
    chk("rst_satp", q0, RST);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_req", req0, 1'b0);
    chk("rst_pulses", {rej0, tmo0, fao0}, 3'b000);
    chk("rst_fasid", fa0, 6'd0);
    rst_n = 1'b1;
    step(1);

    // 1: global flush, ack after a few cycles
    e = mk(4'd1, 6'd5, 22'h1234);
    sb.push_back(e);
    wr0(e);
    chk("t1_req", req0, 1'b1);
    chk("t1_fao", fao0, 1'b0);
    chk("t1_busy", busy0, 1'b1);
    chk("t1_ready", rdy0, 1'b0);
    chk("t1_hold", q0, RST);
    step(2);
    chk("t1_req_held", req0, 1'b1);
    ack0_pulse();
    chk("t1_commit", q0, sb.pop_front());
    chk("t1_ready_up", rdy0, 1'b1);
    chk("t1_req_drop", req0, 1'b0);
    chk("t1_no_tmo", tmo0, 1'b0);

    // ack in IDLE is ignored
    ack0_pulse();
    chk("idle_ack_q", q0, e);
    chk("idle_ack_rdy", rdy0, 1'b1);

    // 2: ASID-only flush
    e = mk(4'd1, 6'd9, 22'h1234);
    sb.push_back(e);
    wr0(e);
    chk("t2_fao", fao0, 1'b1);
    chk("t2_fasid", fa0, 6'd9);
    step(1);
    chk("t2_fasid_hold", fa0, 6'd9);
    ack0_pulse();
    chk("t2_commit", q0, sb.pop_front());
    chk("t2_asid", q0[27:22], 6'd9);

    // 3: identical write, no flush
    sb.push_back(e);
    wr0(e);
    chk("t3_req", req0, 1'b0);
    chk("t3_ready", rdy0, 1'b1);
    chk("t3_q", q0, sb.pop_front());

    // 4: illegal mode, lenient: forced mode plus global flush
    sb.push_back(mk(4'd1, 6'd2, 22'h10));
    wr0(mk(4'd0, 6'd2, 22'h10));
    chk("t4_rej", rej0, 1'b1);
    chk("t4_req", req0, 1'b1);
    chk("t4_fao", fao0, 1'b0);
    step(1);
    chk("t4_rej_pulse", rej0, 1'b0);
    ack0_pulse();
    chk("t4_commit", q0, sb.pop_front());

    // 6a: timeout with no ack
    e = mk(4'd1, 6'd3, 22'h55);
    sb.push_back(e);
    wr0(e);
    n = 0;
    for (int i = 0; i < 10 && req0; i++) begin
      n++;
      chk("t6_no_tmo_yet", tmo0, 1'b0);
      step(1);
    end
    chk("t6_req_cycles", n, 4);
    chk("t6_tmo", tmo0, 1'b1);
    chk("t6_commit", q0, sb.pop_front());
    step(1);
    chk("t6_tmo_pulse", tmo0, 1'b0);

    // 6b: ack on final cycle wins over timeout
    e = mk(4'd1, 6'd4, 22'h66);
    sb.push_back(e);
    wr0(e);
    step(3);
    chk("t6b_req_last", req0, 1'b1);
    ack0_pulse();
    chk("t6b_no_tmo", tmo0, 1'b0);
    chk("t6b_commit", q0, sb.pop_front());
    chk("t6b_ready", rdy0, 1'b1);

    // 6c: reset mid-FLUSH discards pending value
    wr0(mk(4'd1, 6'd7, 22'h77));
    chk("t6c_req", req0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6c_rst_q", q0, RST);
    chk("t6c_rst_req", req0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6c_after_q", q0, RST);

    // 5: strict variant drops illegal write
    wv1 = 1'b1;
    wd1 = mk(4'd0, 6'd3, 22'h20);
    step(1);
    wv1 = 1'b0;
    chk("t5_rej", rej1, 1'b1);
    chk("t5_q", q1, RST);
    chk("t5_req", req1, 1'b0);
    chk("t5_ready", rdy1, 1'b1);
    step(1);
    chk("t5_rej_pulse", rej1, 1'b0);
    chk("t5_quiet", {busy1, fao1, tmo1, fa1}, 9'd0);
    ack1 = 1'b0;

    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
